// File: rtl/sblk_inst_sched.sv
// Generic synchronous FIFO used to queue superblock instruction words.
// Latency: a pushed word is visible at head_dat after the push edge; no bypass.
// Backpressure: caller must not push when full or pop when empty; cnt_nxt_dat lets the caller register its ready.
module sblk_inst_fifo #(
    parameter int WID   = 14,
    parameter int DEPTH = 8
) (
    input  logic                   clk_l,
    input  logic                   rst_n,
    input  logic                   push_vld,
    input  logic [WID-1:0]         push_dat,
    input  logic                   pop_vld,
    output logic [WID-1:0]         head_dat,
    output logic [$clog2(DEPTH):0] cnt_dat,
    output logic [$clog2(DEPTH):0] cnt_nxt_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WID-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_vld);
        rd_ptr_d = rd_ptr_q + AW'(pop_vld);
        cnt_d    = cnt_q + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_l) begin
        if (push_vld) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat    = mem_q[rd_ptr_q];
    assign cnt_dat     = cnt_q;
    assign cnt_nxt_dat = cnt_d;
endmodule

// Instruction scheduler: queues instructions and hands each to one idle superblock, round-robin.
// Latency: earliest dispatch is the edge after the push edge; up to one dispatch per cycle.
// Backpressure: inst_in_rdy (registered) drops when the FIFO fills; hold, busy or locked units stall dispatch.
module sblk_inst_sched #(
    parameter int N_SBLK     = 4,
    parameter int WID_INST   = 14,
    parameter int FIFO_DEPTH = 8,
    parameter int LOCK_CYC   = 2,
    parameter int WID_CNT    = 16
) (
    input  logic                        clk_l,
    input  logic                        rst_n,
    input  logic [WID_INST-1:0]         inst_in_data,
    input  logic                        inst_in_vld,
    output logic                        inst_in_rdy,
    input  logic                        hold,
    input  logic [N_SBLK-1:0]           status_sblk,
    output logic [WID_INST-1:0]         inst_data,
    output logic [N_SBLK-1:0]           inst_en,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic [WID_CNT-1:0]          disp_cnt,
    output logic                        sched_idle
);
    localparam int         PW        = (N_SBLK > 1) ? $clog2(N_SBLK) : 1;
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LOCK_INIT = 4'(LOCK_CYC);

    logic                push, pop;
    logic [WID_INST-1:0] head;
    logic [CW-1:0]       cnt, cnt_nxt;

    logic                rdy_q, rdy_d;
    logic [WID_INST-1:0] inst_data_q, inst_data_d;
    logic [N_SBLK-1:0]   inst_en_q, inst_en_d;
    logic [WID_CNT-1:0]  disp_cnt_q, disp_cnt_d;
    logic                idle_q, idle_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]          lock_q [N_SBLK];
    logic [3:0]          lock_d [N_SBLK];

    logic [N_SBLK-1:0]   avail;
    logic                locks_clr;
    logic                gnt_vld;
    logic [PW-1:0]       gnt_idx;
    int                  scan;

    assign push = inst_in_vld & rdy_q;

    sblk_inst_fifo #(
        .WID   (WID_INST),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l       (clk_l),
        .rst_n       (rst_n),
        .push_vld    (push),
        .push_dat    (inst_in_data),
        .pop_vld     (pop),
        .head_dat    (head),
        .cnt_dat     (cnt),
        .cnt_nxt_dat (cnt_nxt)
    );

    // A unit stays ineligible while its lock runs, covering the delay before status_sblk rises.
    always_comb begin
        avail     = '0;
        locks_clr = 1'b1;
        for (int k = 0; k < N_SBLK; k++) begin
            avail[k] = ~status_sblk[k] & (lock_q[k] == 4'd0);
            if (lock_q[k] != 4'd0) begin
                locks_clr = 1'b0;
            end
        end
    end

    // Scan downward so the eligible unit closest to rr_ptr is the last one written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = 0;
        for (int i = N_SBLK - 1; i >= 0; i--) begin
            scan = int'(rr_ptr_q) + i;
            if (scan >= N_SBLK) begin
                scan = scan - N_SBLK;
            end
            if (avail[scan[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[PW-1:0];
            end
        end
    end

    assign pop = (cnt != '0) & ~hold & gnt_vld;

    always_comb begin
        rdy_d       = (cnt_nxt < CW'(FIFO_DEPTH));
        inst_data_d = inst_data_q;
        inst_en_d   = '0;
        disp_cnt_d  = disp_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        for (int k = 0; k < N_SBLK; k++) begin
            lock_d[k] = (lock_q[k] != 4'd0) ? lock_q[k] - 4'd1 : 4'd0;
        end
        if (pop) begin
            inst_data_d     = head;
            inst_en_d       = N_SBLK'(1) << gnt_idx;
            disp_cnt_d      = disp_cnt_q + WID_CNT'(1);
            rr_ptr_d        = (gnt_idx == PW'(N_SBLK - 1)) ? '0 : gnt_idx + PW'(1);
            lock_d[gnt_idx] = LOCK_INIT;
        end
        idle_d = (cnt_nxt == '0) & ~(|status_sblk) & locks_clr & ~pop;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            inst_data_q <= '0;
            inst_en_q   <= '0;
            disp_cnt_q  <= '0;
            idle_q      <= 1'b0;
            rr_ptr_q    <= '0;
            for (int k = 0; k < N_SBLK; k++) begin
                lock_q[k] <= 4'd0;
            end
        end else begin
            rdy_q       <= rdy_d;
            inst_data_q <= inst_data_d;
            inst_en_q   <= inst_en_d;
            disp_cnt_q  <= disp_cnt_d;
            idle_q      <= idle_d;
            rr_ptr_q    <= rr_ptr_d;
            for (int k = 0; k < N_SBLK; k++) begin
                lock_q[k] <= lock_d[k];
            end
        end
    end

    assign inst_in_rdy = rdy_q;
    assign inst_data   = inst_data_q;
    assign inst_en     = inst_en_q;
    assign fifo_cnt    = cnt;
    assign disp_cnt    = disp_cnt_q;
    assign sched_idle  = idle_q;
endmodule

// File: tb/tb_sblk_inst_sched.sv
// Directed bench for sblk_inst_sched: table of single-cycle vectors plus multi-cycle sequences.
module tb_sblk_inst_sched;
    logic        clk_l;
    logic        rst_n;
    logic [13:0] inst_in_data;
    logic        inst_in_vld;
    logic        inst_in_rdy;
    logic        hold;
    logic [3:0]  status_sblk;
    logic [13:0] inst_data;
    logic [3:0]  inst_en;
    logic [3:0]  fifo_cnt;
    logic [15:0] disp_cnt;
    logic        sched_idle;

    int checks = 0;
    int errors = 0;

    sblk_inst_sched #(
        .N_SBLK     (4),
        .WID_INST   (14),
        .FIFO_DEPTH (8),
        .LOCK_CYC   (2),
        .WID_CNT    (16)
    ) dut (
        .clk_l        (clk_l),
        .rst_n        (rst_n),
        .inst_in_data (inst_in_data),
        .inst_in_vld  (inst_in_vld),
        .inst_in_rdy  (inst_in_rdy),
        .hold         (hold),
        .status_sblk  (status_sblk),
        .inst_data    (inst_data),
        .inst_en      (inst_en),
        .fifo_cnt     (fifo_cnt),
        .disp_cnt     (disp_cnt),
        .sched_idle   (sched_idle)
    );

    initial clk_l = 1'b0;
    always #5 clk_l = ~clk_l;

    typedef struct {
        logic        do_rst;
        logic        vld;
        logic [13:0] dat;
        logic [3:0]  exp_en;
        logic [13:0] exp_dat;
        logic [3:0]  exp_cnt;
        logic        exp_rdy;
        logic        exp_idle;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_l);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        inst_in_vld  = 1'b0;
        inst_in_data = '0;
        hold         = 1'b0;
        status_sblk  = '0;
        #2;
        chk("rst_rdy",  inst_in_rdy, 0);
        chk("rst_en",   inst_en, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_cnt",  fifo_cnt, 0);
        chk("rst_disp", disp_cnt, 0);
        chk("rst_idle", sched_idle, 0);
        @(negedge clk_l);
        rst_n = 1'b1;
        tick();
        chk("rel_rdy",  inst_in_rdy, 1);
        chk("rel_idle", sched_idle, 1);
    endtask

    logic [13:0] t3w [3];
    int          gcyc [3];
    int          ngr;
    logic [13:0] sb [$];
    int          nen;

    initial begin
        rst_n        = 1'b1;
        inst_in_vld  = 1'b0;
        inst_in_data = '0;
        hold         = 1'b0;
        status_sblk  = '0;

        // {rst, vld, dat, en, data, cnt, rdy, idle, disp}
        vecs[0]  = '{1'b0, 1'b1, 14'h1A5, 4'b0000, 14'h000, 4'd1, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 14'h000, 4'b0001, 14'h1A5, 4'd0, 1'b1, 1'b0, 16'd1};
        vecs[2]  = '{1'b0, 1'b0, 14'h000, 4'b0000, 14'h1A5, 4'd0, 1'b1, 1'b0, 16'd1};
        vecs[3]  = '{1'b0, 1'b0, 14'h000, 4'b0000, 14'h1A5, 4'd0, 1'b1, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 1'b0, 14'h000, 4'b0000, 14'h1A5, 4'd0, 1'b1, 1'b1, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 14'h011, 4'b0000, 14'h000, 4'd1, 1'b1, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 14'h022, 4'b0001, 14'h011, 4'd1, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 14'h033, 4'b0010, 14'h022, 4'd1, 1'b1, 1'b0, 16'd2};
        vecs[8]  = '{1'b0, 1'b1, 14'h044, 4'b0100, 14'h033, 4'd1, 1'b1, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 1'b0, 14'h000, 4'b1000, 14'h044, 4'd0, 1'b1, 1'b0, 16'd4};
        vecs[10] = '{1'b0, 1'b0, 14'h000, 4'b0000, 14'h044, 4'd0, 1'b1, 1'b0, 16'd4};

        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_rst) do_reset();
            inst_in_vld  = vecs[i].vld;
            inst_in_data = vecs[i].dat;
            hold         = 1'b0;
            status_sblk  = '0;
            tick();
            chk($sformatf("v%0d_en", i),   inst_en,     vecs[i].exp_en);
            chk($sformatf("v%0d_dat", i),  inst_data,   vecs[i].exp_dat);
            chk($sformatf("v%0d_cnt", i),  fifo_cnt,    vecs[i].exp_cnt);
            chk($sformatf("v%0d_rdy", i),  inst_in_rdy, vecs[i].exp_rdy);
            chk($sformatf("v%0d_idle", i), sched_idle,  vecs[i].exp_idle);
            chk($sformatf("v%0d_disp", i), disp_cnt,    vecs[i].exp_disp);
        end

        // Only unit 2 idle; it is also reported busy for cycles 5..9.
        t3w[0] = 14'h0A1;
        t3w[1] = 14'h0A2;
        t3w[2] = 14'h0A3;
        gcyc[0] = -1;
        gcyc[1] = -1;
        gcyc[2] = -1;
        ngr = 0;
        for (int c = 0; c < 30; c++) begin
            inst_in_vld  = (c < 3);
            inst_in_data = '0;
            if (c < 3) inst_in_data = t3w[c];
            status_sblk = (c >= 5 && c < 10) ? 4'b1111 : 4'b1011;
            tick();
            if (inst_en != 4'b0000) begin
                chk("t3_en", inst_en, 4'b0100);
                if (ngr < 3) begin
                    chk("t3_dat", inst_data, t3w[ngr]);
                    gcyc[ngr] = c;
                end
                ngr++;
            end
        end
        chk("t3_ngr", ngr, 3);
        chk("t3_g0", gcyc[0], 1);
        chk("t3_g1", gcyc[1], 4);
        chk("t3_g2", gcyc[2], 10);

        inst_in_vld = 1'b0;
        status_sblk = '0;
        repeat (3) tick();

        // Fill under hold: ninth word must be refused.
        hold = 1'b1;
        for (int c = 0; c < 9; c++) begin
            inst_in_vld  = 1'b1;
            inst_in_data = 14'h100 + 14'(c);
            if (inst_in_rdy) sb.push_back(inst_in_data);
            tick();
            chk("t4_cnt", fifo_cnt, (c < 8) ? c + 1 : 8);
            chk("t4_rdy", inst_in_rdy, (c < 7) ? 1 : 0);
            chk("t4_en",  inst_en, 0);
        end

        // Release hold, then stream push+pop every cycle, then drain.
        hold = 1'b0;
        for (int c = 0; c < 40; c++) begin
            inst_in_vld  = (c >= 1 && c < 13);
            inst_in_data = 14'h2A0 + 14'(c);
            if (inst_in_vld && inst_in_rdy) sb.push_back(inst_in_data);
            tick();
            if (inst_en != 4'b0000) begin
                chk("t5_onehot", $countones(inst_en), 1);
                if (sb.size() > 0) chk("t5_order", inst_data, sb.pop_front());
                else               chk("t5_extra", inst_en, 0);
            end
            if (c == 0) begin
                chk("t5_rdy_back", inst_in_rdy, 1);
                chk("t5_cnt0",     fifo_cnt, 7);
                chk("t5_en0",      inst_en, 4'b1000);
            end else if (c <= 12) begin
                chk("t5_cnt_const", fifo_cnt, 7);
            end
        end
        inst_in_vld = 1'b0;
        chk("t5_sb_empty", sb.size(), 0);
        chk("t5_cnt_end",  fifo_cnt, 0);
        chk("t5_disp",     disp_cnt, 27);

        // Reset while a grant is on the bus with five words queued.
        repeat (3) tick();
        hold = 1'b1;
        for (int c = 0; c < 6; c++) begin
            inst_in_vld  = 1'b1;
            inst_in_data = 14'h3C0 + 14'(c);
            tick();
        end
        chk("t6_cnt6", fifo_cnt, 6);
        inst_in_vld = 1'b0;
        hold        = 1'b0;
        tick();
        chk("t6_en_live", (inst_en != 4'b0000), 1);
        chk("t6_cnt5",    fifo_cnt, 5);
        do_reset();
        nen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (inst_en != 4'b0000) nen++;
        end
        chk("t6_no_stale", nen, 0);
        chk("t6_cnt",      fifo_cnt, 0);
        chk("t6_disp",     disp_cnt, 0);
        chk("t6_idle",     sched_idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
